// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - SPI NOR word-read sequencer driving a byte-level SPI engine
//
// Turns one host word-read into: CS low, READ opcode + 24-bit address,
// four dummy-clocked data bytes, CS high, then a one-cycle ready pulse.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   valid, addr            host request (held until ready), byte address
//   ready, rdata           one-cycle response pulse, little-endian read word
//   spi_ctrl               0: cs/status register, 1: data register
//   spi_valid, spi_ready   engine request / acknowledge
//   spi_wdata, spi_wstrb   engine write data ([31:8] zero), 4'b0001 write / 4'b0000 read
//   spi_rdata              engine read data, bit31 busy, [7:0] rx byte

module spi_flash_reader #(
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter int         ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 valid,
  input  logic [ADDR_BITS-1:0] addr,
  output logic                 ready,
  output logic [31:0]          rdata,
  output logic                 spi_ctrl,
  output logic                 spi_valid,
  output logic [31:0]          spi_wdata,
  output logic [3:0]           spi_wstrb,
  input  logic [31:0]          spi_rdata,
  input  logic                 spi_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_CSEL, S_SEND, S_POLL, S_FETCH, S_DESEL, S_RESP
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_idx, w_idx_nxt;
  logic [ADDR_BITS-1:0]  r_addr, w_addr_nxt;
  logic [31:0]           r_word, w_word_nxt;
  logic                  r_ready, w_ready_nxt;
  logic [31:0]           r_rdata, w_rdata_nxt;
  logic                  r_spi_valid, w_spi_valid_nxt;
  logic                  r_spi_ctrl, w_spi_ctrl_nxt;
  logic [7:0]            r_spi_wdata, w_spi_wdata_nxt;
  logic [3:0]            r_spi_wstrb, w_spi_wstrb_nxt;

  logic [23:0]           w_addr24;
  logic [7:0]            w_send_byte;
  logic                  w_acc_ctrl;
  logic [7:0]            w_acc_wdata;
  logic [3:0]            w_acc_wstrb;
  logic                  w_unused;

  assign w_addr24  = 24'(r_addr);
  assign w_unused  = ^{spi_rdata[30:8], addr[1:0]};

  assign ready     = r_ready;
  assign rdata     = r_rdata;
  assign spi_valid = r_spi_valid;
  assign spi_ctrl  = r_spi_ctrl;
  assign spi_wdata = {24'h000000, r_spi_wdata};
  assign spi_wstrb = r_spi_wstrb;

  // Byte shifted out in SEND: opcode, address MSB first, then dummies that
  // clock the four data bytes in.
  always_comb begin
    w_send_byte = 8'h00;
    case (r_idx)
      3'd0:    w_send_byte = CMD_READ;
      3'd1:    w_send_byte = w_addr24[23:16];
      3'd2:    w_send_byte = w_addr24[15:8];
      3'd3:    w_send_byte = w_addr24[7:0];
      default: w_send_byte = 8'h00;
    endcase
  end

  // Register access each engine-facing state performs.
  always_comb begin
    w_acc_ctrl  = 1'b0;
    w_acc_wdata = 8'h00;
    w_acc_wstrb = 4'b0000;
    case (r_state)
      S_CSEL:  begin w_acc_ctrl = 1'b0; w_acc_wdata = 8'h01;       w_acc_wstrb = 4'b0001; end
      S_SEND:  begin w_acc_ctrl = 1'b1; w_acc_wdata = w_send_byte; w_acc_wstrb = 4'b0001; end
      S_POLL:  begin w_acc_ctrl = 1'b0; w_acc_wdata = 8'h00;       w_acc_wstrb = 4'b0000; end
      S_FETCH: begin w_acc_ctrl = 1'b1; w_acc_wdata = 8'h00;       w_acc_wstrb = 4'b0000; end
      S_DESEL: begin w_acc_ctrl = 1'b0; w_acc_wdata = 8'h00;       w_acc_wstrb = 4'b0001; end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_addr_nxt      = r_addr;
    w_word_nxt      = r_word;
    w_ready_nxt     = 1'b0;
    w_rdata_nxt     = r_rdata;
    w_spi_valid_nxt = r_spi_valid;
    w_spi_ctrl_nxt  = r_spi_ctrl;
    w_spi_wdata_nxt = r_spi_wdata;
    w_spi_wstrb_nxt = r_spi_wstrb;

    case (r_state)
      S_IDLE: begin
        if (valid) begin
          w_addr_nxt  = {addr[ADDR_BITS-1:2], 2'b00};
          w_idx_nxt   = 3'd0;
          w_state_nxt = S_CSEL;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        if (!r_spi_valid) begin
          // Entering or re-polling: spi_valid was low for at least the
          // previous cycle, so raising it here guarantees the idle gap.
          w_spi_valid_nxt = 1'b1;
          w_spi_ctrl_nxt  = w_acc_ctrl;
          w_spi_wdata_nxt = w_acc_wdata;
          w_spi_wstrb_nxt = w_acc_wstrb;
        end else if (spi_ready) begin
          w_spi_valid_nxt = 1'b0;
          case (r_state)
            S_CSEL: w_state_nxt = S_SEND;
            S_SEND: w_state_nxt = S_POLL;
            S_POLL: begin
              // Busy: stay in POLL; the access is re-issued after the gap.
              if (!spi_rdata[31]) begin
                if (r_idx < 3'd4) begin
                  w_idx_nxt   = r_idx + 3'd1;
                  w_state_nxt = S_SEND;
                end else begin
                  w_state_nxt = S_FETCH;
                end
              end
            end
            S_FETCH: begin
              w_word_nxt[8*r_idx[1:0] +: 8] = spi_rdata[7:0];
              if (r_idx == 3'd7) begin
                w_state_nxt = S_DESEL;
              end else begin
                w_idx_nxt   = r_idx + 3'd1;
                w_state_nxt = S_SEND;
              end
            end
            S_DESEL: begin
              w_ready_nxt = 1'b1;
              w_rdata_nxt = r_word;
              w_state_nxt = S_RESP;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_idx       <= 3'd0;
      r_addr      <= '0;
      r_word      <= 32'h0;
      r_ready     <= 1'b0;
      r_rdata     <= 32'h0;
      r_spi_valid <= 1'b0;
      r_spi_ctrl  <= 1'b0;
      r_spi_wdata <= 8'h00;
      r_spi_wstrb <= 4'b0000;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_addr      <= w_addr_nxt;
      r_word      <= w_word_nxt;
      r_ready     <= w_ready_nxt;
      r_rdata     <= w_rdata_nxt;
      r_spi_valid <= w_spi_valid_nxt;
      r_spi_ctrl  <= w_spi_ctrl_nxt;
      r_spi_wdata <= w_spi_wdata_nxt;
      r_spi_wstrb <= w_spi_wstrb_nxt;
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb/tb_spi_flash_reader.sv - scoreboard bench for spi_flash_reader with a behavioural SPI engine and flash
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid;
  logic [23:0] addr;
  logic        ready;
  logic [31:0] rdata;
  logic        spi_ctrl;
  logic        spi_valid;
  logic [31:0] spi_wdata;
  logic [3:0]  spi_wstrb;
  logic [31:0] spi_rdata;
  logic        spi_ready;

  always #5 clk = ~clk;

  spi_flash_reader #(.CMD_READ(8'h03), .ADDR_BITS(24)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .addr(addr),
    .ready(ready), .rdata(rdata), .spi_ctrl(spi_ctrl), .spi_valid(spi_valid),
    .spi_wdata(spi_wdata), .spi_wstrb(spi_wstrb), .spi_rdata(spi_rdata),
    .spi_ready(spi_ready)
  );

  typedef struct {
    logic [31:0] word;
    logic [63:0] mosi;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] flash [logic [23:0]];

  // engine model state
  int          cyc = 0;
  int          lat = 1;
  int          busy_long_idx = -1;
  int          hs_err = 0;
  int          hold_err = 0;
  int          eng_nbytes = 0;
  int          eng_busy = 0;
  int          eng_cnt = 0;
  int          busy_polls = 0;
  int          frame_start_cyc = -1;
  int          prev_ready_cyc = -1;
  bit          eng_pending = 0;
  bit          eng_cs_low = 0;
  logic [63:0] eng_mosi = '0;
  logic [23:0] eng_fa = '0;
  logic [7:0]  eng_rx = 8'hFF;
  logic        cap_ctrl;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] flash_rd(input logic [23:0] a);
    if (flash.exists(a)) return flash[a];
    return 8'h00;
  endfunction

  task automatic eng_access();
    case ({cap_ctrl, cap_wstrb})
      5'b0_0001: begin
        eng_cs_low = cap_wdata[0];
        if (cap_wdata[0]) begin
          eng_nbytes = 0;
          eng_mosi = '0;
          frame_start_cyc = cyc;
          busy_polls = 0;
        end
      end
      5'b1_0001: begin
        if (!eng_cs_low || eng_busy != 0) hs_err++;
        eng_mosi = {eng_mosi[55:0], cap_wdata[7:0]};
        if (eng_nbytes == 3) eng_fa = eng_mosi[23:0];
        if (eng_nbytes >= 4) eng_rx = flash_rd(eng_fa + 24'(eng_nbytes - 4));
        else eng_rx = 8'hFF;
        eng_busy = (eng_nbytes == busy_long_idx) ? 100 : 16;
        eng_nbytes++;
      end
      5'b0_0000: begin
        spi_rdata = {(eng_busy != 0), 23'd0, eng_rx};
        if (eng_busy != 0) busy_polls++;
      end
      5'b1_0000: begin
        spi_rdata = {(eng_busy != 0), 23'd0, eng_rx};
        if (eng_busy != 0) hs_err++;
      end
      default: hs_err++;
    endcase
  endtask

  // Engine: one-shot ready pulse `lat` cycles after spi_valid rises.
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!resetn) begin
        eng_pending = 0;
        spi_ready = 1'b0;
        eng_cs_low = 0;
        eng_busy = 0;
      end else begin
        if (eng_busy > 0) eng_busy--;
        if (spi_ready) begin
          spi_ready = 1'b0;
          eng_pending = 0;
          if (spi_valid) hs_err++;
        end else if (eng_pending) begin
          if (!spi_valid || spi_ctrl !== cap_ctrl || spi_wdata !== cap_wdata ||
              spi_wstrb !== cap_wstrb) hs_err++;
          eng_cnt--;
          if (eng_cnt == 0) begin
            eng_access();
            spi_ready = 1'b1;
          end
        end else if (spi_valid) begin
          eng_pending = 1;
          eng_cnt = lat;
          cap_ctrl = spi_ctrl;
          cap_wdata = spi_wdata;
          cap_wstrb = spi_wstrb;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every ready pulse.
  initial begin
    bit          prev_ready = 0;
    logic [31:0] last_rdata = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        last_rdata = '0;
        prev_ready = 0;
      end else if (ready) begin
        check("ready_single_pulse", prev_ready, 0);
        if (sb_q.size() == 0) begin
          check("unexpected_ready", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("rdata", rdata, e.word);
          check("mosi_bytes", eng_mosi, e.mosi);
          check("byte_count", eng_nbytes, 8);
          check("cs_high_before_ready", eng_cs_low, 0);
          check("engine_handshake_errors", hs_err, 0);
          check("frame_after_prev_resp", frame_start_cyc > prev_ready_cyc, 1);
        end
        prev_ready_cyc = cyc;
        last_rdata = rdata;
        prev_ready = 1;
      end else begin
        if (rdata !== last_rdata) hold_err++;
        prev_ready = 0;
      end
    end
  end

  task automatic do_read(input logic [23:0] a, input logic [31:0] w, input logic [63:0] m);
    exp_t e;
    bit   got;
    e.word = w;
    e.mosi = m;
    sb_q.push_back(e);
    valid = 1'b1;
    addr  = a;
    got   = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (i == 4) addr = ~a;
      if (ready) begin
        got = 1;
        break;
      end
    end
    if (!got) check("ready_timeout", 0, 1);
    valid = 1'b0;
    addr  = 24'h0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_spi_valid"}, spi_valid, 0);
    check({tag, "_spi_ctrl"}, spi_ctrl, 0);
    check({tag, "_spi_wdata"}, spi_wdata, 0);
    check({tag, "_spi_wstrb"}, spi_wstrb, 0);
  endtask

  initial begin
    bit hit;
    resetn = 1'b0; valid = 1'b0; addr = '0; spi_ready = 1'b0; spi_rdata = '0;
    flash[24'h000104] = 8'h11; flash[24'h000105] = 8'h22; flash[24'h000106] = 8'h33; flash[24'h000107] = 8'h44;
    flash[24'hFFFFFC] = 8'hA1; flash[24'hFFFFFD] = 8'hB2; flash[24'hFFFFFE] = 8'hC3; flash[24'hFFFFFF] = 8'hD4;
    flash[24'h000000] = 8'hDE; flash[24'h000001] = 8'hAD; flash[24'h000002] = 8'hBE; flash[24'h000003] = 8'hEF;
    flash[24'h000004] = 8'h01; flash[24'h000005] = 8'h02; flash[24'h000006] = 8'h03; flash[24'h000007] = 8'h04;
    flash[24'h002468] = 8'h55; flash[24'h002469] = 8'h66; flash[24'h00246A] = 8'h77; flash[24'h00246B] = 8'h88;
    flash[24'h000010] = 8'h99; flash[24'h000011] = 8'hAA; flash[24'h000012] = 8'hBB; flash[24'h000013] = 8'hCC;
    flash[24'h000020] = 8'h0F; flash[24'h000021] = 8'h1E; flash[24'h000022] = 8'h2D; flash[24'h000023] = 8'h3C;
    flash[24'h000030] = 8'hC0; flash[24'h000031] = 8'hFF; flash[24'h000032] = 8'hEE; flash[24'h000033] = 8'h00;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);

    do_read(24'h000104, 32'h44332211, 64'h03000104_00000000);
    do_read(24'hFFFFFF, 32'hD4C3B2A1, 64'h03FFFFFC_00000000);

    busy_long_idx = 2;
    do_read(24'h002468, 32'h88776655, 64'h03002468_00000000);
    check("long_busy_polls_ge10", busy_polls >= 10, 1);
    busy_long_idx = -1;

    do_read(24'h000000, 32'hEFBEADDE, 64'h03000000_00000000);
    do_read(24'h000004, 32'h04030201, 64'h03000004_00000000);

    // Abort during the second data fetch; nothing is queued for it.
    valid = 1'b1;
    addr  = 24'h000010;
    hit   = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (spi_valid && spi_ctrl && spi_wstrb == 4'b0000 && eng_nbytes == 6) begin
        hit = 1;
        break;
      end
    end
    check("reached_fetch_idx5", hit, 1);
    resetn = 1'b0;
    #1;
    check_reset_outputs("abort");
    valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    do_read(24'h000020, 32'h3C2D1E0F, 64'h03000020_00000000);

    lat = 3;
    do_read(24'h000033, 32'h00EEFFC0, 64'h03000030_00000000);
    lat = 1;

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    check("rdata_hold_errors", hold_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
